// File: rtl/log2_code_checker.sv
// Golden-response monitor for the floor(log2(i)) encoder stream: decodes each
// received code to its index range, checks it against a local sweep index, and flags a trojan.
module log2_code_checker #(
  parameter int IDX_W        = 10,
  parameter int CODE_W       = 4,
  parameter int CNT_W        = 11,
  parameter int ALARM_THRESH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code_in,
  output logic              code_ready,
  output logic              busy,
  output logic              done,
  output logic              alarm,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  mism_cnt,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [CODE_W-1:0] fail_code,
  output logic [IDX_W-1:0]  dec_lo,
  output logic [IDX_W-1:0]  dec_hi
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             beat, clr;
  logic             legal, hit, counted;
  logic [IDX_W:0]   lo_w, hi_w;
  logic [IDX_W-1:0] lo_c, hi_c;
  logic [CNT_W-1:0] mism_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign beat       = (state == RUN) && code_valid;
  assign clr        = start && (state != RUN);
  assign code_ready = (state == RUN);
  assign busy       = (state == RUN);
  assign done       = (state == DONE);

  // Decode the incoming code to [2^n, 2^(n+1)-1]; computed one bit wide so n=IDX_W-1 fits
  always_comb begin
    legal   = int'(code_in) < IDX_W;
    lo_w    = '0;
    hi_w    = '0;
    if (legal) begin
      lo_w = (IDX_W+1)'(1) << code_in;
      hi_w = ((IDX_W+1)'(2) << code_in) - (IDX_W+1)'(1);
    end
    lo_c     = lo_w[IDX_W-1:0];
    hi_c     = hi_w[IDX_W-1:0];
    hit      = legal && (idx >= lo_c) && (idx <= hi_c);
    counted  = (idx != '0);
    mism_inc = sat_inc(mism_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (code_valid && (idx == '1)) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      match_cnt <= '0;
      mism_cnt  <= '0;
      fail_idx  <= '0;
      fail_code <= '0;
      dec_lo    <= '0;
      dec_hi    <= '0;
      alarm     <= 1'b0;
    end else if (clr) begin
      idx       <= '0;
      match_cnt <= '0;
      mism_cnt  <= '0;
      fail_idx  <= '0;
      fail_code <= '0;
      dec_lo    <= '0;
      dec_hi    <= '0;
      alarm     <= 1'b0;
    end else if (beat) begin
      idx    <= idx + 1'b1;
      dec_lo <= lo_c;
      dec_hi <= hi_c;
      // Index 0 has no defined encoder output, so it is decoded but never scored
      if (counted) begin
        if (hit) begin
          match_cnt <= sat_inc(match_cnt);
        end else begin
          mism_cnt <= mism_inc;
          if (mism_cnt == '0) begin
            fail_idx  <= idx;
            fail_code <= code_in;
          end
          if (mism_inc >= CNT_W'(ALARM_THRESH)) alarm <= 1'b1;
        end
      end
    end
  end

endmodule
